// File: rtl/boot_rom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_rom_pkg                                                         |
// | Shared constants and response payload type for the boot ROM port.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package boot_rom_pkg;

  localparam logic [31:0] BOOT_ROM_BASE  = 32'h0000_8000;
  localparam int unsigned BOOT_ROM_DEPTH = 548;
  localparam int unsigned BOOT_ROM_AW    = 10;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } boot_rom_resp_t;

endpackage
`default_nettype wire

// File: rtl/boot_rom_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_rom_resp_fifo                                                   |
// | Two-entry response buffer; same-cycle push and pop are allowed.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  boot_rom_resp_t push_data,
  input  logic           pop,
  output boot_rom_resp_t pop_data,
  output logic [1:0]     cnt
);

  boot_rom_resp_t mem_q [2];
  boot_rom_resp_t mem_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && cnt_q == 2'd0));

endmodule
`default_nettype wire

// File: rtl/boot_rom_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_rom_if                                                          |
// | Bus front end for the boot ROM: in-order word reads, error replies.  |
// | Define BOOT_ROM_IF_ERR_EN to enable address/write error decoding.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module boot_rom_if
  import boot_rom_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
  parameter int unsigned ROM_DEPTH = BOOT_ROM_DEPTH,
  parameter int unsigned ROM_AW    = BOOT_ROM_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  output logic              GNT,
  input  logic [31:0]       ADDR,
  input  logic              WE,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic              ERR,
  output logic              ROM_CSN,
  output logic [ROM_AW-1:0] ROM_A,
  input  logic [31:0]       ROM_Q
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_DEPTH) << 2;

  logic           s1_valid_q, s1_valid_d;
  logic           s1_err_q, s1_err_d;
  logic [31:0]    off;
  logic [ROM_AW-1:0] idx;
  logic           bad;
  logic           rom_rd;
  logic [1:0]     fifo_cnt;
  logic           fifo_push, fifo_pop;
  boot_rom_resp_t fifo_head, s1_resp, head;

  always_comb begin
    off = ADDR - BASE_ADDR;
    idx = off[ROM_AW+1:2];
`ifdef BOOT_ROM_IF_ERR_EN
    bad = (ADDR < BASE_ADDR) || (off[1:0] != 2'b00) || (off >= ROM_BYTES) || WE;
`else
    bad = 1'b0;
`endif
  end

  logic unused_ok;
  assign unused_ok = ^{WE, off[31:ROM_AW+2], off[1:0]};

  always_comb begin
    // Grant depends only on REQ and occupancy so it never waits on RREADY.
    GNT        = REQ && (({1'b0, fifo_cnt} + {2'b00, s1_valid_q}) < 3'd2);
    rom_rd     = GNT && !bad;
    ROM_CSN    = !rom_rd;
    ROM_A      = rom_rd ? idx : '0;
    s1_valid_d = GNT;
    s1_err_d   = GNT && bad;

    s1_resp.data = s1_err_q ? 32'd0 : ROM_Q;
    s1_resp.err  = s1_err_q;
    head         = (fifo_cnt != 2'd0) ? fifo_head : s1_resp;

    RVALID = (fifo_cnt != 2'd0) || s1_valid_q;
    RDATA  = RVALID ? head.data : 32'd0;
    ERR    = RVALID && head.err;

    // s1 bypasses the buffer only when it is the head and is taken now.
    fifo_pop  = (fifo_cnt != 2'd0) && RREADY;
    fifo_push = s1_valid_q && ((fifo_cnt != 2'd0) || !RREADY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
    end
  end

  boot_rom_resp_fifo u_resp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (fifo_push),
    .push_data (s1_resp),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .cnt       (fifo_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_boot_rom_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_boot_rom_if                                                       |
// | Randomized bench for boot_rom_if against a queue-based reference.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_boot_rom_if;
  import boot_rom_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          DEPTH = 548;
`ifdef BOOT_ROM_IF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, REQ, WE, RREADY;
  logic        GNT, RVALID, ERR, ROM_CSN;
  logic [31:0] ADDR, RDATA;
  logic [31:0] ROM_Q;
  logic [9:0]  ROM_A;

  logic [31:0]    rom [1024];
  boot_rom_resp_t exp_q [$];
  int             n_cmp = 0;
  int             n_mis = 0;

  boot_rom_if dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .ADDR(ADDR), .WE(WE),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .ERR(ERR),
    .ROM_CSN(ROM_CSN), .ROM_A(ROM_A), .ROM_Q(ROM_Q)
  );

  always #5 CLK = ~CLK;

  // ROM macro: registered address, data valid the cycle after select.
  always @(posedge CLK) if (!ROM_CSN) ROM_Q <= rom[ROM_A];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int ref_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off / 4) % 1024);
  endfunction

  function automatic boot_rom_resp_t ref_resp(input logic [31:0] addr, input logic we);
    longint off_s;
    bit     bad;
    boot_rom_resp_t r;
    off_s = longint'(addr) - longint'(BASE);
    bad   = ERR_EN && (off_s < 0 || (off_s % 4) != 0 || off_s >= 4 * DEPTH || we);
    r.err  = bad;
    r.data = bad ? 32'd0 : rom[ref_idx(addr)];
    return r;
  endfunction

  // Apply inputs, compare outputs against the reference, advance one clock.
  task automatic step(input logic rq, input logic [31:0] ad, input logic w,
                      input logic rr, input logic rs, output logic got_gnt);
    bit             ev, eg;
    boot_rom_resp_t r;
    REQ = rq; ADDR = ad; WE = w; RREADY = rr; RST = rs;
    #2;
    got_gnt = GNT;
    if (!rs) begin
      ev = exp_q.size() > 0;
      eg = rq && exp_q.size() < 2;
      r  = ref_resp(ad, w);
      chk("gnt", {31'd0, GNT}, {31'd0, eg});
      chk("rvalid", {31'd0, RVALID}, {31'd0, ev});
      chk("rdata", RDATA, ev ? exp_q[0].data : 32'd0);
      chk("err", {31'd0, ERR}, {31'd0, ev ? exp_q[0].err : 1'b0});
      chk("rom_csn", {31'd0, ROM_CSN}, {31'd0, !(eg && !r.err)});
      chk("rom_a", {22'd0, ROM_A}, (eg && !r.err) ? 32'(ref_idx(ad)) : 32'd0);
      if (ev && rr) void'(exp_q.pop_front());
      if (eg) exp_q.push_back(r);
    end
    @(posedge CLK);
    if (rs) exp_q.delete();
    @(negedge CLK);
  endtask

  initial begin
    logic        g;
    int          gcnt;
    logic [31:0] a;
    logic [31:0] bnd [5];
    logic        bwe [5];

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;

    step(0, 0, 0, 1, 1, g);
    step(0, 0, 0, 1, 1, g);
    step(0, 0, 0, 1, 0, g);  // reset state

    // back-to-back reads
    for (int i = 0; i < 3; i++) step(1, BASE + 32'(4 * i), 0, 1, 0, g);
    step(0, 0, 0, 1, 0, g);

    // response stall under continuous requests
    gcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, BASE + 32'(4 * (i + 10)), 0, 0, 0, g);
      gcnt += int'(g);
    end
    chk("stall_grants", 32'(gcnt), 32'd2);
    for (int i = 0; i < 3; i++) step(1, BASE + 32'(4 * (i + 20)), 0, 1, 0, g);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, g);

    // boundaries and error cases
    bnd[0] = BASE + 32'(4 * (DEPTH - 1)); bwe[0] = 0;
    bnd[1] = BASE + 32'(4 * DEPTH);       bwe[1] = 0;
    bnd[2] = BASE - 32'd4;                bwe[2] = 0;
    bnd[3] = BASE + 32'd2;                bwe[3] = 0;
    bnd[4] = BASE;                        bwe[4] = 1;
    for (int i = 0; i < 5; i++) step(1, bnd[i], bwe[i], 1, 0, g);
    step(1, BASE + 32'd4, 1, 1, 0, g);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, g);

    // randomized interleaving
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        3:       a = BASE + 32'(4 * $urandom_range(DEPTH - 8, DEPTH + 12));
        4:       a = BASE - 32'(4 * $urandom_range(1, 4));
        default: a = BASE + 32'($urandom_range(0, 40));
      endcase
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) != 0), 0, g);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, g);

    // reset with two responses outstanding
    step(1, BASE + 32'd8, 0, 0, 0, g);
    step(1, BASE + 32'd12, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, g);
    step(0, 0, 0, 1, 0, g);
    step(1, BASE + 32'h10, 0, 1, 0, g);
    step(0, 0, 0, 1, 0, g);
    chk("post_rst_word4_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
